// File: rtl/mult_ctrl_pkg.sv
// mult_ctrl_pkg: state encoding and cycle-count helpers for the shift-add multiplier controller
package mult_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, ADD, SUB, SHIFT, DONE} mult_state_t;
  localparam int unsigned CLEAR_CYCLES = 1;
  function automatic int unsigned busy_cycles(int unsigned n, int unsigned p);
    return CLEAR_CYCLES + n + p;
  endfunction
endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// shift_add_mult_ctrl_if: handshake and strobe bundle between the multiplier controller and its datapath/top level
interface shift_add_mult_ctrl_if #(parameter int N = 8, parameter int CW = $clog2(N));
  logic Run, ClearA_LoadB, Signed_Mode, M;
  logic Clr_Ld, Clr_A, Add, Sub, Shift_En, Busy, Done;
  logic [CW-1:0] Bit_Idx;
  modport master(output Run, ClearA_LoadB, Signed_Mode, M,
                 input Clr_Ld, Clr_A, Add, Sub, Shift_En, Busy, Done, Bit_Idx);
  modport slave(input Run, ClearA_LoadB, Signed_Mode, M,
                output Clr_Ld, Clr_A, Add, Sub, Shift_En, Busy, Done, Bit_Idx);
endinterface

// File: rtl/bit_counter.sv
// bit_counter: index of the multiplier bit being processed, with terminal count at N-1
module bit_counter #(parameter int N = 8, parameter int CW = $clog2(N)) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + CW'(1);
  assign tc = cnt == CW'(N - 1);
endmodule

// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: sequences clear/add/sub/shift steps of an N-bit shift-add multiplier
module shift_add_mult_ctrl import mult_ctrl_pkg::*; #(parameter int N = 8, parameter int CW = $clog2(N)) (
  input logic Clk,
  input logic Reset,
  shift_add_mult_ctrl_if.slave bus
);
  mult_state_t state, next, decide;
  logic mode_q, tc, pre_last;
  logic [CW-1:0] cnt;
  bit_counter #(.N(N), .CW(CW)) u_cnt (
    .Clk(Clk), .Reset(Reset), .clr(state == CLEAR), .inc(state == SHIFT && !tc), .cnt(cnt), .tc(tc)
  );
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) mode_q <= 1'b0;
    else if (state == IDLE && bus.Run) mode_q <= bus.Signed_Mode;
  // the bit decided on leaving SHIFT is cnt+1, so it is the sign bit when cnt is N-2
  assign pre_last = state == SHIFT && cnt == CW'(N - 2);
  assign decide = !bus.M ? SHIFT : (pre_last && mode_q) ? SUB : ADD;
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = bus.Run ? CLEAR : IDLE;
      CLEAR:    next = decide;
      ADD, SUB: next = SHIFT;
      SHIFT:    next = tc ? DONE : decide;
      DONE:     next = bus.Run ? DONE : IDLE;
      default:  next = IDLE;
    endcase
  end
  always_comb begin
    bus.Clr_Ld   = (state == IDLE || state == DONE) && bus.ClearA_LoadB;
    bus.Clr_A    = state == CLEAR;
    bus.Add      = state == ADD;
    bus.Sub      = state == SUB;
    bus.Shift_En = state == SHIFT;
    bus.Busy     = state == CLEAR || state == ADD || state == SUB || state == SHIFT;
    bus.Done     = state == DONE;
    bus.Bit_Idx  = cnt;
  end
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb_shift_add_mult_ctrl: table-driven multiply runs with a scoreboard of expected step sequences
module tb_shift_add_mult_ctrl;
  import mult_ctrl_pkg::*;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic run, clab, sm, m, sel4;
  shift_add_mult_ctrl_if #(.N(8)) b8();
  shift_add_mult_ctrl_if #(.N(4)) b4();
  shift_add_mult_ctrl #(.N(8)) dut8 (.Clk(clk), .Reset(rst), .bus(b8.slave));
  shift_add_mult_ctrl #(.N(4)) dut4 (.Clk(clk), .Reset(rst), .bus(b4.slave));
  assign b8.Run = run & !sel4;
  assign b4.Run = run & sel4;
  assign b8.ClearA_LoadB = clab;
  assign b4.ClearA_LoadB = clab;
  assign b8.Signed_Mode = sm;
  assign b4.Signed_Mode = sm;
  assign b8.M = m;
  assign b4.M = m;
  logic o_clr_ld, o_clr_a, o_add, o_sub, o_shift, o_busy, o_done;
  logic [2:0] o_idx;
  assign o_clr_ld = sel4 ? b4.Clr_Ld : b8.Clr_Ld;
  assign o_clr_a  = sel4 ? b4.Clr_A : b8.Clr_A;
  assign o_add    = sel4 ? b4.Add : b8.Add;
  assign o_sub    = sel4 ? b4.Sub : b8.Sub;
  assign o_shift  = sel4 ? b4.Shift_En : b8.Shift_En;
  assign o_busy   = sel4 ? b4.Busy : b8.Busy;
  assign o_done   = sel4 ? b4.Done : b8.Done;
  assign o_idx    = sel4 ? {1'b0, b4.Bit_Idx} : b8.Bit_Idx;

  typedef struct { bit sel4; bit sgn; logic [7:0] pat; int busy; int adds; int subs; } vec_t;
  typedef struct { string seq; int busy; int adds; int subs; } exp_t;
  vec_t vt[8];
  exp_t sbq[$];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chks(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  // C=clear, A=add, U=subtract, S=shift; one letter per busy cycle
  function automatic string exp_seq(input int n, input bit sgn, input logic [7:0] pat);
    string s = "C";
    string a = "A";
    string u = "U";
    string sh = "S";
    for (int i = 0; i < n; i++) begin
      if (pat[i]) s = {s, (sgn && i == n - 1) ? u : a};
      s = {s, sh};
    end
    return s;
  endfunction

  function automatic int outs();
    return int'({o_clr_ld, o_clr_a, o_add, o_sub, o_shift, o_busy, o_done, o_idx});
  endfunction

  task automatic run_vec(input vec_t v, input int rst_at);
    int n = v.sel4 ? 4 : 8;
    int nshift = 0, busy = 0, adds = 0, subs = 0, idx_bad = 0, ld_bad = 0, excl_bad = 0, hold_bad = 0;
    bit got_done = 0;
    string seq = "";
    string ch;
    exp_t e;
    sbq.push_back('{exp_seq(n, v.sgn, v.pat), v.busy, v.adds, v.subs});
    @(negedge clk);
    sel4 = v.sel4; sm = v.sgn; m = v.pat[0]; clab = 0; run = 1;
    for (int c = 0; c < int'(busy_cycles(n, n)) + 5 && !got_done; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin sm = ~v.sgn; clab = 1; end
      if (o_done) got_done = 1;
      else begin
        ch = o_clr_a ? "C" : o_add ? "A" : o_sub ? "U" : o_shift ? "S" : "-";
        seq = {seq, ch};
        busy += int'(o_busy); adds += int'(o_add); subs += int'(o_sub);
        if ($countones({o_clr_a, o_add, o_sub, o_shift}) > 1) excl_bad++;
        if (o_clr_ld) ld_bad++;
        if (o_shift) begin
          if (o_idx != 3'(nshift)) idx_bad++;
          if (rst_at == nshift) begin
            clab = 0; rst = 1; #1;
            chk("rst_async_outputs", outs(), 0);
            void'(sbq.pop_front());
            run = 0;
            @(negedge clk); rst = 0;
            return;
          end
          nshift++;
        end
        m = nshift < n ? v.pat[nshift] : 1'b0;
      end
    end
    chk("done_seen", int'(got_done), 1);
    chk("sb_depth", sbq.size(), 1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chks("step_seq", seq, e.seq);
      chk("busy_cycles", busy, e.busy);
      chk("add_pulses", adds, e.adds);
      chk("sub_pulses", subs, e.subs);
    end
    chk("bit_idx_steps", idx_bad, 0);
    chk("strobe_exclusive", excl_bad, 0);
    chk("clr_ld_while_busy", ld_bad, 0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (!(o_done && !o_busy && !o_clr_a && o_clr_ld)) hold_bad++;
    end
    chk("done_hold_no_retrigger", hold_bad, 0);
    @(negedge clk); run = 0; clab = 0;
    @(posedge clk); #1;
    chk("idle_after_release", int'({o_done, o_busy}), 0);
  endtask

  initial begin
    int bad = 0;
    vt[0] = '{0, 0, 8'h00,  9, 0, 0};
    vt[1] = '{0, 1, 8'hFF, 17, 7, 1};
    vt[2] = '{0, 0, 8'hFF, 17, 8, 0};
    vt[3] = '{1, 1, 8'h09,  7, 1, 1};
    vt[4] = '{0, 1, 8'hA5, 13, 3, 1};
    vt[5] = '{0, 0, 8'h80, 10, 1, 0};
    vt[6] = '{0, 1, 8'h7F, 16, 7, 0};
    vt[7] = '{1, 0, 8'h0F,  9, 4, 0};
    run = 0; clab = 0; sm = 0; m = 0; sel4 = 0;
    #1;
    chk("reset_values", outs(), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (outs() != 0) bad++;
    end
    chk("idle_run_low", bad, 0);
    clab = 1; #1;
    chk("clr_ld_in_idle", int'(o_clr_ld), 1);
    chk("busy_in_idle", int'(o_busy), 0);
    clab = 0;
    foreach (vt[i]) run_vec(vt[i], -1);
    run_vec(vt[0], 2);
    chk("idle_after_reset", outs(), 0);
    run_vec(vt[0], -1);
    run_vec(vt[1], -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
